// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID bundle
interface fetch_stage_if;
  logic        pc_write;
  logic        ifid_write;
  logic        en_iw;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic [3:0]  if_id_rn1;
  logic [3:0]  if_id_rn2;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    input  pc_write, ifid_write, en_iw, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, if_id_rn1, if_id_rn2,
           stall_count, flush_count
  );

  modport slave (
    output pc_write, ifid_write, en_iw, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, if_id_rn1, if_id_rn2,
           stall_count, flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, IF/ID pipeline register and stall/flush counters
module fetch_stage (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fs
);
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // imem_addr comes straight from the PC register, so redirects land one edge later
  assign fs.imem_addr   = pc;
  assign fs.if_id_instr = instr_q;
  assign fs.if_id_pc    = pc_q;
  assign fs.if_id_valid = valid_q;
  assign fs.if_id_rn1   = instr_q[7:4];
  assign fs.if_id_rn2   = instr_q[3:0];
  assign fs.stall_count = stall_cnt;
  assign fs.flush_count = flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 16'h0000;
    end else if (fs.branch_taken) begin
      pc <= fs.branch_target;
    end else if (fs.pc_write) begin
      pc <= pc + 16'h0001;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= 16'h0000;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else if (fs.branch_taken) begin
      instr_q <= 16'h0000;
      pc_q    <= pc;
      valid_q <= 1'b0;
    end else if (fs.ifid_write && fs.en_iw) begin
      instr_q <= fs.imem_data;
      pc_q    <= pc;
      valid_q <= 1'b1;
    end
  end

  // Saturating counters: stalls only count when no flush overrides them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (!fs.branch_taken && !fs.pc_write && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 16'h0000;
    end else if (fs.branch_taken && flush_cnt != 16'hFFFF) begin
      flush_cnt <= flush_cnt + 16'h0001;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_stage_if ifc ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .fs  (ifc)
  );

  always #5 clk = ~clk;

  // Instruction memory: 0x1234 at address 0, otherwise addr ^ 0xA500
  always_comb begin
    ifc.imem_data = (ifc.imem_addr == 16'h0000) ? 16'h1234 : (ifc.imem_addr ^ 16'hA500);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  ifc.imem_addr,   16'h0000);
    check({tag, "_instr"}, ifc.if_id_instr, 16'h0000);
    check({tag, "_pc"},    ifc.if_id_pc,    16'h0000);
    check({tag, "_valid"}, ifc.if_id_valid, 1'b0);
    check({tag, "_stall"}, ifc.stall_count, 16'h0000);
    check({tag, "_flush"}, ifc.flush_count, 16'h0000);
  endtask

  initial begin
    ifc.pc_write      = 1'b1;
    ifc.ifid_write    = 1'b1;
    ifc.en_iw         = 1'b1;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = 16'h0000;

    step();
    check_reset_vals("reset");

    // First fetch from address 0
    rst = 1'b0;
    step();
    check("f1_instr", ifc.if_id_instr, 16'h1234);
    check("f1_pc",    ifc.if_id_pc,    16'h0000);
    check("f1_valid", ifc.if_id_valid, 1'b1);
    check("f1_rn1",   ifc.if_id_rn1,   4'h3);
    check("f1_rn2",   ifc.if_id_rn2,   4'h4);
    check("f1_addr",  ifc.imem_addr,   16'h0001);

    repeat (4) step();
    check("seq_addr",  ifc.imem_addr,   16'h0005);
    check("seq_instr", ifc.if_id_instr, 16'hA504);

    // Two-edge stall at PC=5
    ifc.pc_write   = 1'b0;
    ifc.ifid_write = 1'b0;
    repeat (2) step();
    check("stall_addr",  ifc.imem_addr,   16'h0005);
    check("stall_instr", ifc.if_id_instr, 16'hA504);
    check("stall_pc",    ifc.if_id_pc,    16'h0004);
    check("stall_cnt",   ifc.stall_count, 16'h0002);
    ifc.pc_write   = 1'b1;
    ifc.ifid_write = 1'b1;
    step();
    check("unstall_addr",  ifc.imem_addr,   16'h0006);
    check("unstall_instr", ifc.if_id_instr, 16'hA505);
    check("unstall_cnt",   ifc.stall_count, 16'h0002);

    // Plain flush
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 16'h0040;
    step();
    check("fl_addr",  ifc.imem_addr,   16'h0040);
    check("fl_instr", ifc.if_id_instr, 16'h0000);
    check("fl_valid", ifc.if_id_valid, 1'b0);
    check("fl_pc",    ifc.if_id_pc,    16'h0006);
    check("fl_cnt",   ifc.flush_count, 16'h0001);
    ifc.branch_taken = 1'b0;
    step();
    check("postfl_valid", ifc.if_id_valid, 1'b1);
    check("postfl_pc",    ifc.if_id_pc,    16'h0040);
    check("postfl_instr", ifc.if_id_instr, 16'hA540);
    check("postfl_addr",  ifc.imem_addr,   16'h0041);

    // en_iw=0 holds IF/ID while the PC advances
    ifc.en_iw = 1'b0;
    step();
    check("noiw_addr",  ifc.imem_addr,   16'h0042);
    check("noiw_instr", ifc.if_id_instr, 16'hA540);
    check("noiw_pc",    ifc.if_id_pc,    16'h0040);
    ifc.en_iw = 1'b1;

    // Flush wins over a simultaneous stall
    ifc.pc_write      = 1'b0;
    ifc.ifid_write    = 1'b0;
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 16'h0080;
    step();
    check("flst_addr",  ifc.imem_addr,   16'h0080);
    check("flst_instr", ifc.if_id_instr, 16'h0000);
    check("flst_valid", ifc.if_id_valid, 1'b0);
    check("flst_pc",    ifc.if_id_pc,    16'h0042);
    check("flst_fcnt",  ifc.flush_count, 16'h0002);
    check("flst_scnt",  ifc.stall_count, 16'h0002);
    ifc.pc_write     = 1'b1;
    ifc.ifid_write   = 1'b1;
    ifc.branch_taken = 1'b0;
    step();
    check("postflst_valid", ifc.if_id_valid, 1'b1);
    check("postflst_pc",    ifc.if_id_pc,    16'h0080);
    check("postflst_instr", ifc.if_id_instr, 16'hA580);

    // Back-to-back branches redirect on each edge
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 16'h0010;
    step();
    check("bb1_addr", ifc.imem_addr, 16'h0010);
    ifc.branch_target = 16'h0020;
    step();
    check("bb2_addr",  ifc.imem_addr,   16'h0020);
    check("bb2_pc",    ifc.if_id_pc,    16'h0010);
    check("bb2_valid", ifc.if_id_valid, 1'b0);
    check("bb2_cnt",   ifc.flush_count, 16'h0004);

    // PC wrap at 0xFFFF
    ifc.branch_target = 16'hFFFF;
    step();
    check("wrap_pre", ifc.imem_addr, 16'hFFFF);
    ifc.branch_taken = 1'b0;
    step();
    check("wrap_addr",  ifc.imem_addr,   16'h0000);
    check("wrap_pc",    ifc.if_id_pc,    16'hFFFF);
    check("wrap_instr", ifc.if_id_instr, 16'h5AFF);

    // Reset pulsed between edges during a stall
    ifc.pc_write   = 1'b0;
    ifc.ifid_write = 1'b0;
    step();
    check("prerst_scnt", ifc.stall_count, 16'h0003);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    ifc.pc_write   = 1'b1;
    ifc.ifid_write = 1'b1;
    step();
    check("rel_addr",  ifc.imem_addr,   16'h0001);
    check("rel_instr", ifc.if_id_instr, 16'h1234);
    check("rel_pc",    ifc.if_id_pc,    16'h0000);
    check("rel_valid", ifc.if_id_valid, 1'b1);
    check("rel_scnt",  ifc.stall_count, 16'h0000);

    // Stall counter saturation through real stall edges
    ifc.pc_write = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    check("ssat_reach", ifc.stall_count, 16'hFFFF);
    repeat (3) step();
    check("ssat_hold", ifc.stall_count, 16'hFFFF);
    ifc.pc_write = 1'b1;

    // Flush counter saturation from a preloaded value
    @(negedge clk);
    force dut.flush_cnt = 16'hFFFE;
    #1;
    release dut.flush_cnt;
    check("fsat_pre", ifc.flush_count, 16'hFFFE);
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 16'h0100;
    step();
    check("fsat_reach", ifc.flush_count, 16'hFFFF);
    repeat (3) step();
    check("fsat_hold", ifc.flush_count, 16'hFFFF);
    check("fsat_scnt", ifc.stall_count, 16'hFFFF);
    ifc.branch_taken = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL provide port pc_write, input, 1 bit: 1 allows the PC to advance; 0 holds the PC (load-use stall).
REQ-004 The block SHALL provide port ifid_write, input, 1 bit: 1 allows the IF/ID register to load; 0 holds it.
REQ-005 The block SHALL provide port en_iw, input, 1 bit: instruction-write enable; the IF/ID register loads only when ifid_write=1 and en_iw=1.
REQ-006 The block SHALL provide port branch_taken, input, 1 bit: redirect request from EX.
REQ-007 The block SHALL provide port branch_target, input, 16 bits: redirect word address.
REQ-008 The block SHALL provide port imem_data, input, 16 bits: instruction at imem_addr, combinational memory read.
REQ-009 The block SHALL provide port imem_addr, output, 16 bits: the current PC, driven combinationally.
REQ-010 The block SHALL provide port if_id_instr, output, 16 bits: registered instruction.
REQ-011 The block SHALL provide port if_id_pc, output, 16 bits: PC of the registered instruction.
REQ-012 The block SHALL provide port if_id_valid, output, 1 bit: 0 marks a bubble.
REQ-013 The block SHALL provide ports if_id_rn1 and if_id_rn2, outputs, 4 bits each: if_id_instr[7:4] and if_id_instr[3:0], driven combinationally from the register, for the hazard unit.
REQ-014 The block SHALL provide ports stall_count and flush_count, outputs, 16 bits each: performance counters.

Function
REQ-015 The PC SHALL be a 16-bit word address; the sequential next PC is PC+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-016 On each rising edge, the block SHALL select the update case by priority: flush (branch_taken=1), then stall, then normal.
REQ-017 Flush: PC <= branch_target; if_id_instr <= 16'h0000 (NOP); if_id_valid <= 0; if_id_pc <= current PC; pc_write, ifid_write and en_iw are ignored.
REQ-018 Stall (no flush, pc_write=0): PC holds.
REQ-019 Normal (no flush, pc_write=1): PC <= PC+1.
REQ-020 When there is no flush and ifid_write=1 and en_iw=1, the IF/ID register SHALL load if_id_instr <= imem_data, if_id_pc <= PC, and if_id_valid <= 1.
REQ-021 When there is no flush and either ifid_write=0 or en_iw=0, the IF/ID register (instr, pc, valid) SHALL hold.
REQ-022 PC and IF/ID gating SHALL be independent: pc_write=1 with ifid_write=0 advances the PC and holds IF/ID.
REQ-023 stall_count SHALL increment by 1 on each edge with pc_write=0 and branch_taken=0, and saturate at 16'hFFFF.
REQ-024 flush_count SHALL increment by 1 on each edge with branch_taken=1, and saturate at 16'hFFFF.
REQ-025 Latency: an instruction presented on imem_data SHALL appear on if_id_instr one edge later; a redirect SHALL appear on imem_addr one edge after branch_taken is sampled.
REQ-026 A flush SHALL last exactly one edge per branch_taken=1 cycle; a branch_taken held high for consecutive cycles SHALL re-redirect to branch_target on each of those edges.
REQ-027 The block SHALL contain no combinational path from any input to imem_addr.

Reset
REQ-028 While rst=1, the block SHALL force, immediately and independently of clk: PC=16'h0000, if_id_instr=16'h0000, if_id_pc=16'h0000, if_id_valid=0, stall_count=0, flush_count=0.
REQ-029 On the first rising edge after rst deasserts, the block SHALL perform a normal fetch from address 0 (subject to pc_write, ifid_write and en_iw).
REQ-030 Assertion of rst mid-stall or mid-flush SHALL abandon that operation with no residual state.

Verification
REQ-031 The bench SHALL cover: release reset, imem_data=16'h1234 at addr 0, all enables 1 -> after edge 1: if_id_instr=16'h1234, if_id_pc=0, if_id_valid=1, rn1=4'h3, rn2=4'h4, imem_addr=1.
REQ-032 The bench SHALL cover: PC=5, pc_write=0 and ifid_write=0 for 2 edges -> imem_addr stays 5, IF/ID unchanged, stall_count increases by 2; after release, next edge gives imem_addr=6.
REQ-033 The bench SHALL cover: branch_taken=1 with branch_target=16'h0040 -> next edge: imem_addr=16'h0040, if_id_instr=16'h0000, if_id_valid=0, flush_count increases by 1; the following edge gives valid=1 with if_id_pc=16'h0040.
REQ-034 The bench SHALL cover: branch_taken=1 simultaneous with pc_write=0 and ifid_write=0 -> flush behaviour exactly as in REQ-033, stall_count unchanged.
REQ-035 The bench SHALL cover: PC=16'hFFFF with normal fetch -> imem_addr=16'h0000 next; counters preloaded to 16'hFFFF via repeated events stay at 16'hFFFF.
REQ-036 The bench SHALL cover: rst pulsed between clock edges during a stall -> all outputs at reset values before the next edge; a normal fetch from 0 follows release.
